// File: rtl/pacote_riscv.sv
// Shared definitions for the fetch front end: word size, canonical NOP,
// PC step and the {pc, instr} pair that travels from fetch to decode.
package pacote_riscv;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_INCREMENTO = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } par_instr_t;

  // Forces a byte address onto a word boundary.
  function automatic logic [XLEN-1:0] alinha_palavra(input logic [XLEN-1:0] endereco);
    return {endereco[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/busca_instrucao_chk.sv
// Invariants of the fetch stage: outstanding-request bounds, discard
// bookkeeping and FIFO overflow/underflow.
module busca_instrucao_chk #(
  parameter int PROFUNDIDADE = 2,
  parameter int CW           = 2
) (
  input logic          clk,
  input logic          rst,
  input logic [CW-1:0] pendentes,
  input logic [CW-1:0] descartar,
  input logic [CW-1:0] tag_count,
  input logic          push_saida,
  input logic          pop_saida,
  input logic          saida_cheia,
  input logic          tag_push,
  input logic          tag_pop,
  input logic          tag_cheia,
  input logic          tag_vazia
);

  localparam logic [CW-1:0] LIMITE = CW'(PROFUNDIDADE);

  a_pendentes_limite: assert property (@(posedge clk) disable iff (rst) pendentes <= LIMITE);
  a_descartar_limite: assert property (@(posedge clk) disable iff (rst) descartar <= pendentes);
  a_tags_coerentes:   assert property (@(posedge clk) disable iff (rst) tag_count == pendentes);
  a_saida_sem_estouro: assert property (@(posedge clk) disable iff (rst)
                                        !(push_saida && saida_cheia && !pop_saida));
  a_tag_sem_estouro:  assert property (@(posedge clk) disable iff (rst)
                                        !(tag_push && tag_cheia && !tag_pop));
  a_resposta_esperada: assert property (@(posedge clk) disable iff (rst) !(tag_pop && tag_vazia));

endmodule

// File: rtl/fila_instrucao.sv
// Synchronous FIFO with flush. The depth must be a power of two so the
// pointers wrap by plain overflow.
module fila_instrucao #(
  parameter int LARGURA      = 64,
  parameter int PROFUNDIDADE = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          push,
  input  logic                          pop,
  input  logic [LARGURA-1:0]            dado_push,
  output logic [LARGURA-1:0]            dado_topo,
  output logic [$clog2(PROFUNDIDADE):0] count,
  output logic                          cheia,
  output logic                          vazia
);

  localparam int PW = $clog2(PROFUNDIDADE);
  localparam logic [PW:0]   CAPACIDADE = (PW+1)'(PROFUNDIDADE);
  localparam logic [PW:0]   UM_C       = (PW+1)'(1);
  localparam logic [PW:0]   ZERO_C     = (PW+1)'(0);
  localparam logic [PW-1:0] UM_P       = PW'(1);
  localparam logic [PW-1:0] ZERO_P     = PW'(0);

  logic [LARGURA-1:0] memoria_r [PROFUNDIDADE];
  logic [PW-1:0]      rd_ptr_r;
  logic [PW-1:0]      wr_ptr_r;
  logic [PW:0]        count_r;
  logic               escreve_s;
  logic               le_s;

  assign cheia     = (count_r == CAPACIDADE);
  assign vazia     = (count_r == ZERO_C);
  assign escreve_s = push && (!cheia || pop);
  assign le_s      = pop && !vazia;
  assign dado_topo = memoria_r[rd_ptr_r];
  assign count     = count_r;

  // Pointers and occupancy; a flush empties the queue without touching storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_r <= ZERO_P;
      wr_ptr_r <= ZERO_P;
      count_r  <= ZERO_C;
    end else if (flush) begin
      rd_ptr_r <= ZERO_P;
      wr_ptr_r <= ZERO_P;
      count_r  <= ZERO_C;
    end else begin
      if (escreve_s) wr_ptr_r <= wr_ptr_r + UM_P;
      if (le_s)      rd_ptr_r <= rd_ptr_r + UM_P;
      case ({escreve_s, le_s})
        2'b10:   count_r <= count_r + UM_C;
        2'b01:   count_r <= count_r - UM_C;
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PROFUNDIDADE; i++) memoria_r[i] <= {LARGURA{1'b0}};
    end else if (escreve_s && !flush) begin
      memoria_r[wr_ptr_r] <= dado_push;
    end
  end

endmodule

// File: rtl/busca_instrucao.sv
// Instruction fetch: owns the PC, issues credit-limited word reads, pairs each
// response with its PC and queues the pair for decode; redirects drop stale work.
module busca_instrucao
  import pacote_riscv::*;
#(
  parameter logic [XLEN-1:0] PC_RESET     = 32'h0000_0000,
  parameter int              PROFUNDIDADE = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            desvio,
  input  logic [XLEN-1:0] desvio_alvo,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instrucao,
  output logic [XLEN-1:0] pc_out
);

  localparam int CW = $clog2(PROFUNDIDADE) + 1;
  localparam logic [CW-1:0] UM     = CW'(1);
  localparam logic [CW-1:0] ZERO   = CW'(0);
  localparam logic [CW:0]   LIMITE = (CW+1)'(PROFUNDIDADE);

  logic [XLEN-1:0] pc_r;
  logic [CW-1:0]   pendentes_r;
  logic [CW-1:0]   descartar_r;
  logic [CW-1:0]   saida_count_s;
  logic [CW-1:0]   tag_count_s;
  logic [CW:0]     ocupacao_s;
  logic            req_valid_s;
  logic            req_fire_s;
  logic            push_saida_s;
  logic            pop_saida_s;
  logic            saida_cheia_s;
  logic            saida_vazia_s;
  logic            tag_cheia_s;
  logic            tag_vazia_s;
  logic [XLEN-1:0] tag_topo_s;
  par_instr_t      par_push_s;
  par_instr_t      par_topo_s;

  // Words in flight plus words queued never exceed the FIFO depth, so a
  // response always finds room.
  assign ocupacao_s   = {1'b0, pendentes_r} + {1'b0, saida_count_s};
  assign req_valid_s  = !rst && !desvio && (ocupacao_s < LIMITE);
  assign req_fire_s   = req_valid_s && mem_req_ready;
  assign push_saida_s = mem_resp_valid && (descartar_r == ZERO) && !desvio;
  assign pop_saida_s  = !saida_vazia_s && instr_ready && !desvio;
  assign par_push_s   = {tag_topo_s, mem_rdata};

  assign mem_req_valid = req_valid_s;
  assign mem_addr      = pc_r;
  assign instr_valid   = !saida_vazia_s;
  assign instrucao     = saida_vazia_s ? {XLEN{1'b0}} : par_topo_s.instr;
  assign pc_out        = saida_vazia_s ? {XLEN{1'b0}} : par_topo_s.pc;

  // Program counter: redirect wins over sequential advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r <= PC_RESET;
    end else if (desvio) begin
      pc_r <= alinha_palavra(desvio_alvo);
    end else if (req_fire_s) begin
      pc_r <= pc_r + PC_INCREMENTO;
    end
  end

  // Requests accepted by memory but not yet answered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pendentes_r <= ZERO;
    end else begin
      case ({req_fire_s, mem_resp_valid})
        2'b10:   pendentes_r <= pendentes_r + UM;
        2'b01:   pendentes_r <= pendentes_r - UM;
        default: pendentes_r <= pendentes_r;
      endcase
    end
  end

  // Responses still owed to pre-redirect requests; recomputed from the live
  // count so back-to-back redirects stay consistent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      descartar_r <= ZERO;
    end else if (desvio) begin
      descartar_r <= mem_resp_valid ? (pendentes_r - UM) : pendentes_r;
    end else if (mem_resp_valid && (descartar_r != ZERO)) begin
      descartar_r <= descartar_r - UM;
    end
  end

  // PC tags of outstanding requests; never flushed, discarded responses pop them.
  fila_instrucao #(
    .LARGURA      (XLEN),
    .PROFUNDIDADE (PROFUNDIDADE)
  ) u_tags (
    .clk       (clk),
    .rst       (rst),
    .flush     (1'b0),
    .push      (req_fire_s),
    .pop       (mem_resp_valid),
    .dado_push (pc_r),
    .dado_topo (tag_topo_s),
    .count     (tag_count_s),
    .cheia     (tag_cheia_s),
    .vazia     (tag_vazia_s)
  );

  fila_instrucao #(
    .LARGURA      (2*XLEN),
    .PROFUNDIDADE (PROFUNDIDADE)
  ) u_saida (
    .clk       (clk),
    .rst       (rst),
    .flush     (desvio),
    .push      (push_saida_s),
    .pop       (pop_saida_s),
    .dado_push (par_push_s),
    .dado_topo (par_topo_s),
    .count     (saida_count_s),
    .cheia     (saida_cheia_s),
    .vazia     (saida_vazia_s)
  );

  busca_instrucao_chk #(
    .PROFUNDIDADE (PROFUNDIDADE),
    .CW           (CW)
  ) u_chk (
    .clk         (clk),
    .rst         (rst),
    .pendentes   (pendentes_r),
    .descartar   (descartar_r),
    .tag_count   (tag_count_s),
    .push_saida  (push_saida_s),
    .pop_saida   (pop_saida_s),
    .saida_cheia (saida_cheia_s),
    .tag_push    (req_fire_s),
    .tag_pop     (mem_resp_valid),
    .tag_cheia   (tag_cheia_s),
    .tag_vazia   (tag_vazia_s)
  );

endmodule

// File: tb/tb_busca_instrucao.sv
// Directed bench for busca_instrucao: per-cycle vector table against an
// in-order 1-cycle memory model, plus wrap-around and async-reset sequences.
module tb_busca_instrucao;

  typedef struct {
    int          rep;
    logic [3:0]  ctl;      // {mem_req_ready, resp_en, instr_ready, desvio}
    logic [31:0] alvo;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
  } vec_t;

  logic        clk, rst;
  logic        mem_req_valid, mem_req_ready, mem_resp_valid, desvio, instr_valid, instr_ready;
  logic [31:0] mem_addr, mem_rdata, desvio_alvo, instrucao, pc_out;
  logic        req_valid_b, req_ready_b, resp_valid_b, iv_b;
  logic [31:0] addr_b, rdata_b, instr_b, pc_b;

  logic [31:0] fila_mem[$];
  logic [31:0] fila_b[$];
  logic [31:0] cap_b[4];
  int          cap_n;
  int          n_checks, n_errors;
  vec_t        tab[$];
  vec_t        tab_rst[$];

  busca_instrucao #(.PC_RESET(32'h0000_0000), .PROFUNDIDADE(2)) dut (
    .clk(clk), .rst(rst),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .desvio(desvio), .desvio_alvo(desvio_alvo),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instrucao(instrucao), .pc_out(pc_out)
  );

  busca_instrucao #(.PC_RESET(32'hFFFF_FFF8), .PROFUNDIDADE(2)) dut_b (
    .clk(clk), .rst(rst),
    .mem_req_valid(req_valid_b), .mem_req_ready(req_ready_b), .mem_addr(addr_b),
    .mem_resp_valid(resp_valid_b), .mem_rdata(rdata_b),
    .desvio(1'b0), .desvio_alvo(32'h0000_0000),
    .instr_valid(iv_b), .instr_ready(1'b1),
    .instrucao(instr_b), .pc_out(pc_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its end, got running, expected finished");
    $fatal(1);
  end

  function automatic logic [31:0] palavra(input logic [31:0] a);
    case (a)
      32'h0000_0000: palavra = 32'h0050_0093;
      32'h0000_0004: palavra = 32'h00A0_0113;
      default:       palavra = {a[15:0], 16'h0013};
    endcase
  endfunction

  function automatic vec_t mk(input int rep, input logic [3:0] ctl, input logic [31:0] alvo,
                              input logic e_req, input logic [31:0] e_addr, input logic e_iv,
                              input logic [31:0] e_instr, input logic [31:0] e_pc);
    vec_t v;
    v.rep = rep; v.ctl = ctl; v.alvo = alvo; v.e_req = e_req; v.e_addr = e_addr;
    v.e_iv = e_iv; v.e_instr = e_instr; v.e_pc = e_pc;
    return v;
  endfunction

  task automatic chk(input string nome, input int idx, input logic [31:0] atual, input logic [31:0] esperado);
    n_checks++;
    if (atual !== esperado) begin
      n_errors++;
      $display("FAIL %s (passo %0d): got 0x%08h, expected 0x%08h", nome, idx, atual, esperado);
    end
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, then advance both memory models.
  task automatic passo(input vec_t v, input int idx);
    logic fire, resp, fire_b, resp_b;
    logic [31:0] a, a_b;
    mem_req_ready  = v.ctl[3];
    instr_ready    = v.ctl[1];
    desvio         = v.ctl[0];
    desvio_alvo    = v.alvo;
    mem_resp_valid = v.ctl[2] && (fila_mem.size() > 0);
    mem_rdata      = (fila_mem.size() > 0) ? palavra(fila_mem[0]) : 32'h0000_0000;
    resp_valid_b   = (fila_b.size() > 0);
    rdata_b        = (fila_b.size() > 0) ? palavra(fila_b[0]) : 32'h0000_0000;
    #1;
    chk("mem_req_valid", idx, {31'b0, mem_req_valid}, {31'b0, v.e_req});
    if (v.e_req) chk("mem_addr", idx, mem_addr, v.e_addr);
    chk("instr_valid", idx, {31'b0, instr_valid}, {31'b0, v.e_iv});
    if (v.e_iv) begin
      chk("instrucao", idx, instrucao, v.e_instr);
      chk("pc_out", idx, pc_out, v.e_pc);
    end
    fire   = mem_req_valid && mem_req_ready;
    resp   = mem_resp_valid;
    a      = mem_addr;
    fire_b = req_valid_b && req_ready_b;
    resp_b = resp_valid_b;
    a_b    = addr_b;
    if (fire_b && cap_n < 4) begin
      cap_b[cap_n] = a_b;
      cap_n++;
    end
    @(posedge clk);
    #1;
    if (resp) void'(fila_mem.pop_front());
    if (fire) fila_mem.push_back(a);
    if (resp_b) void'(fila_b.pop_front());
    if (fire_b) fila_b.push_back(a_b);
  endtask

  initial begin
    int idx;
    n_checks = 0; n_errors = 0; cap_n = 0;
    for (int i = 0; i < 4; i++) cap_b[i] = 32'hDEAD_BEEF;
    rst = 1'b1; mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = 32'h0;
    desvio = 1'b0; desvio_alvo = 32'h0; instr_ready = 1'b0;
    req_ready_b = 1'b1; resp_valid_b = 1'b0; rdata_b = 32'h0;

    // Free-running fetch, then a 10-cycle decode stall.
    tab.push_back(mk(1,  4'b1110, 32'h0,   1'b1, 32'h0000_0000, 1'b0, 32'h0,          32'h0));
    tab.push_back(mk(1,  4'b1110, 32'h0,   1'b1, 32'h0000_0004, 1'b0, 32'h0,          32'h0));
    tab.push_back(mk(1,  4'b1110, 32'h0,   1'b0, 32'h0,         1'b1, 32'h0050_0093,  32'h0000_0000));
    tab.push_back(mk(1,  4'b1110, 32'h0,   1'b1, 32'h0000_0008, 1'b1, 32'h00A0_0113,  32'h0000_0004));
    tab.push_back(mk(1,  4'b1110, 32'h0,   1'b1, 32'h0000_000C, 1'b0, 32'h0,          32'h0));
    tab.push_back(mk(10, 4'b1100, 32'h0,   1'b0, 32'h0,         1'b1, 32'h0008_0013,  32'h0000_0008));
    tab.push_back(mk(1,  4'b1110, 32'h0,   1'b0, 32'h0,         1'b1, 32'h0008_0013,  32'h0000_0008));
    tab.push_back(mk(1,  4'b1110, 32'h0,   1'b1, 32'h0000_0010, 1'b1, 32'h000C_0013,  32'h0000_000C));
    // Two outstanding, redirect to 0x102: both late responses dropped.
    tab.push_back(mk(1,  4'b1010, 32'h0,   1'b1, 32'h0000_0014, 1'b0, 32'h0,          32'h0));
    tab.push_back(mk(1,  4'b1011, 32'h102, 1'b0, 32'h0,         1'b0, 32'h0,          32'h0));
    tab.push_back(mk(1,  4'b1110, 32'h0,   1'b0, 32'h0,         1'b0, 32'h0,          32'h0));
    tab.push_back(mk(1,  4'b1110, 32'h0,   1'b1, 32'h0000_0100, 1'b0, 32'h0,          32'h0));
    tab.push_back(mk(1,  4'b1110, 32'h0,   1'b1, 32'h0000_0104, 1'b0, 32'h0,          32'h0));
    tab.push_back(mk(1,  4'b1110, 32'h0,   1'b0, 32'h0,         1'b1, 32'h0100_0013,  32'h0000_0100));
    // Redirect together with a response and a decode pop.
    tab.push_back(mk(1,  4'b1100, 32'h0,   1'b1, 32'h0000_0108, 1'b1, 32'h0104_0013,  32'h0000_0104));
    tab.push_back(mk(1,  4'b1111, 32'h200, 1'b0, 32'h0,         1'b1, 32'h0104_0013,  32'h0000_0104));
    tab.push_back(mk(1,  4'b1110, 32'h0,   1'b1, 32'h0000_0200, 1'b0, 32'h0,          32'h0));
    tab.push_back(mk(1,  4'b1110, 32'h0,   1'b1, 32'h0000_0204, 1'b0, 32'h0,          32'h0));
    tab.push_back(mk(1,  4'b1110, 32'h0,   1'b0, 32'h0,         1'b1, 32'h0200_0013,  32'h0000_0200));
    // Two pending, redirect coincides with a response: only one more is dropped.
    tab.push_back(mk(1,  4'b1010, 32'h0,   1'b1, 32'h0000_0208, 1'b1, 32'h0204_0013,  32'h0000_0204));
    tab.push_back(mk(1,  4'b1010, 32'h0,   1'b1, 32'h0000_020C, 1'b0, 32'h0,          32'h0));
    tab.push_back(mk(1,  4'b1111, 32'h303, 1'b0, 32'h0,         1'b0, 32'h0,          32'h0));
    tab.push_back(mk(1,  4'b1110, 32'h0,   1'b1, 32'h0000_0300, 1'b0, 32'h0,          32'h0));
    tab.push_back(mk(1,  4'b1110, 32'h0,   1'b1, 32'h0000_0304, 1'b0, 32'h0,          32'h0));
    tab.push_back(mk(1,  4'b1110, 32'h0,   1'b0, 32'h0,         1'b1, 32'h0300_0013,  32'h0000_0300));
    // Back-to-back redirects: the second target wins.
    tab.push_back(mk(1,  4'b1111, 32'h400, 1'b0, 32'h0,         1'b1, 32'h0304_0013,  32'h0000_0304));
    tab.push_back(mk(1,  4'b1111, 32'h500, 1'b0, 32'h0,         1'b0, 32'h0,          32'h0));
    tab.push_back(mk(1,  4'b1110, 32'h0,   1'b1, 32'h0000_0500, 1'b0, 32'h0,          32'h0));
    tab.push_back(mk(1,  4'b1110, 32'h0,   1'b1, 32'h0000_0504, 1'b0, 32'h0,          32'h0));
    tab.push_back(mk(1,  4'b1110, 32'h0,   1'b0, 32'h0,         1'b1, 32'h0500_0013,  32'h0000_0500));

    tab_rst.push_back(mk(1, 4'b1110, 32'h0, 1'b1, 32'h0000_0000, 1'b0, 32'h0,         32'h0));
    tab_rst.push_back(mk(1, 4'b1110, 32'h0, 1'b1, 32'h0000_0004, 1'b0, 32'h0,         32'h0));
    tab_rst.push_back(mk(1, 4'b1110, 32'h0, 1'b0, 32'h0,         1'b1, 32'h0050_0093, 32'h0000_0000));
    tab_rst.push_back(mk(1, 4'b1110, 32'h0, 1'b1, 32'h0000_0008, 1'b1, 32'h00A0_0113, 32'h0000_0004));

    repeat (3) @(posedge clk);
    #1;
    chk("reset mem_req_valid", 0, {31'b0, mem_req_valid}, 32'h0);
    chk("reset mem_addr", 0, mem_addr, 32'h0000_0000);
    chk("reset instr_valid", 0, {31'b0, instr_valid}, 32'h0);
    chk("reset instrucao", 0, instrucao, 32'h0);
    chk("reset pc_out", 0, pc_out, 32'h0);
    chk("reset mem_addr wrap dut", 0, addr_b, 32'hFFFF_FFF8);
    @(negedge clk);
    rst = 1'b0;

    idx = 0;
    foreach (tab[r]) begin
      for (int k = 0; k < tab[r].rep; k++) begin
        passo(tab[r], idx);
        idx++;
      end
    end

    chk("wrap request count", idx, cap_n, 32'd4);
    chk("wrap addr0", idx, cap_b[0], 32'hFFFF_FFF8);
    chk("wrap addr1", idx, cap_b[1], 32'hFFFF_FFFC);
    chk("wrap addr2", idx, cap_b[2], 32'h0000_0000);
    chk("wrap addr3", idx, cap_b[3], 32'h0000_0004);

    // Build two pending requests, then assert reset between clock edges.
    passo(mk(1, 4'b1010, 32'h0, 1'b1, 32'h0000_0508, 1'b1, 32'h0504_0013, 32'h0000_0504), idx); idx++;
    passo(mk(1, 4'b1000, 32'h0, 1'b1, 32'h0000_050C, 1'b0, 32'h0, 32'h0), idx); idx++;
    #3;
    rst = 1'b1;
    #1;
    chk("async rst mem_req_valid", idx, {31'b0, mem_req_valid}, 32'h0);
    chk("async rst mem_addr", idx, mem_addr, 32'h0000_0000);
    chk("async rst instr_valid", idx, {31'b0, instr_valid}, 32'h0);
    chk("async rst instrucao", idx, instrucao, 32'h0);
    chk("async rst pc_out", idx, pc_out, 32'h0);
    fila_mem.delete();
    fila_b.delete();
    mem_resp_valid = 1'b0;
    resp_valid_b   = 1'b0;
    mem_req_ready  = 1'b1;
    @(posedge clk);
    #1;
    chk("held rst mem_req_valid", idx, {31'b0, mem_req_valid}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    foreach (tab_rst[r]) begin
      passo(tab_rst[r], idx);
      idx++;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/busca_instrucao.md
Name: busca_instrucao

Overview:
- Instruction-fetch stage. Sits directly upstream of the decode stage; its `instrucao` output feeds the decoder and immediate generator.
- Holds the PC and issues word reads to instruction memory over a valid/ready request channel with in-order responses.
- Buffers returned words in a 2-entry FIFO and presents them to decode with a valid/ready handshake.
- Accepts branch/jump redirects from execute and discards all stale fetches.

Parameters:
- PC_RESET, 32'h0000_0000, PC value after reset.
- PROFUNDIDADE, 2, FIFO depth; also the maximum number of outstanding requests (supported values: 2 or 4).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- mem_req_valid  output  1  fetch request valid
- mem_req_ready  input  1  memory accepts request
- mem_addr  output  32  word address of request (bits [1:0] always 0)
- mem_resp_valid  input  1  read data valid; responses in request order, at least 1 cycle after acceptance
- mem_rdata  input  32  instruction word
- desvio  input  1  redirect pulse from execute
- desvio_alvo  input  32  redirect target
- instr_valid  output  1  `instrucao` / `pc_out` valid toward decode
- instr_ready  input  1  decode accepts
- instrucao  output  32  instruction word to decode
- pc_out  output  32  PC of `instrucao`

Behaviour:
- Reset (async assert, sync release) sets:
  - pc = PC_RESET
  - all counters (pendentes, descartar, FIFO count, FIFO pointers) = 0
  - mem_req_valid = 0, instr_valid = 0, instrucao = 0, pc_out = 0
- Credit rule: mem_req_valid = !rst && !desvio && (pendentes + fifo_count < PROFUNDIDADE).
  - The FIFO can therefore never overflow; no response is ever dropped for lack of space.
- mem_addr = pc whenever mem_req_valid = 1.
- Request handshake (mem_req_valid && mem_req_ready): pc <= pc + 4 (32-bit wrap, 32'hFFFF_FFFC -> 0); pendentes += 1.
- Each request's PC is pushed into a parallel PC tag FIFO at issue. The response pairs with the head tag.
- Response (mem_resp_valid):
  - pendentes -= 1.
  - If descartar > 0: descartar -= 1 and the word is discarded (its tag is also popped).
  - Otherwise push {tag, mem_rdata} into the output FIFO.
- Output: instr_valid = (fifo_count != 0). `instrucao` and `pc_out` show the FIFO head. Pop when instr_valid && instr_ready.
- Ordering and latency:
  - Simultaneous push and pop is allowed and leaves the count unchanged.
  - No bypass: data appears at the output the cycle after the response, so minimum fetch-to-decode latency is 2 cycles after request acceptance.
- Redirect (desvio = 1, single cycle):
  - pc <= {desvio_alvo[31:2], 2'b00}.
  - Output FIFO and output-pair tags are flushed; instr_valid = 0 on the next cycle.
  - descartar <= pendentes minus 1 if a response arrives in the same cycle (that response is itself discarded).
  - No request is issued in the redirect cycle.
  - A pop in the redirect cycle is ignored (the flush wins).
- Back-to-back redirects: the second one overrides the target. descartar is recomputed from the live pendentes, so it stays correct.
- Decode stall (instr_ready = 0 indefinitely): fetching stops once pendentes + fifo_count = PROFUNDIDADE. `instrucao` stays stable while instr_valid && !instr_ready.
- Reset mid-operation: all state clears immediately. The memory is expected to also be reset; late responses after reset are not supported.
- Assertions for verification:
  - pendentes <= PROFUNDIDADE
  - descartar <= pendentes
  - no push when the FIFO is full

Decomposition:
- Shared package (pacote_riscv): XLEN = 32, INSTR_NOP = 32'h0000_0013, width of PC increment (4).
- One sub-module: fila_instrucao. A parameterised synchronous FIFO (data + PC, 64 bits wide) with push, pop, flush, count, full and empty. The top keeps the PC, counters and credit logic.

Test Plan:
- Reset release, memory always ready, 1-cycle responses with words 0x00500093, 0x00A00113, instr_ready = 1.
  - Expected: mem_addr 0x0, 0x4, 0x8…; decode receives (pc 0x0, 0x00500093) then (0x4, 0x00A00113), back to back.
- instr_ready = 0 held for 10 cycles.
  - Expected: exactly 2 requests issued; instr_valid = 1 with `instrucao` stable; mem_req_valid = 0 until the first pop.
- Two outstanding requests, then desvio with target 0x0000_0102.
  - Expected: both late responses discarded; next mem_addr = 0x0000_0100; first delivered pc_out = 0x100.
- Redirect in the same cycle as a response and a decode pop.
  - Expected: that response discarded, FIFO empty next cycle, descartar = pendentes - 1, no stray instruction delivered.
- PC_RESET = 32'hFFFF_FFF8, free-running fetch.
  - Expected: mem_addr sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
- rst asserted asynchronously mid-burst with 2 pending requests.
  - Expected: outputs zero within the same cycle; after release, fetch restarts at PC_RESET with no stale delivery.
